// File: rtl/bf_data_mem_sched.sv
// Tape RAM scheduler: shares one single-port RAM between the core and the display scanner and runs the tape-clear sequence.
// Optional starvation guard for the display port is enabled by defining BF_STARVE_GUARD_EN.
module bf_data_mem_sched #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 256
`ifdef BF_STARVE_GUARD_EN
   , parameter int STARVE_LIM = 8
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // state    | meaning
   // ST_CLEAR | writing zero to cells 0..MEM_DEPTH-1, one per cycle, no grants
   // ST_SERVE | arbitrating core/display accesses, one grant per cycle
   typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MEM_DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
   logic              core_rvalid_q, disp_rvalid_q;
   logic              disp_first;

`ifdef BF_STARVE_GUARD_EN
   logic [3:0] starve_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
      end else if (state == ST_SERVE) begin
         if (!disp_req || disp_gnt)
            starve_cnt <= 4'd0;
         else if (starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // >= rather than == so a clear landing on the limit cycle cannot push the count past it for good
   assign disp_first = disp_req && (starve_cnt >= 4'(STARVE_LIM));
`else
   assign disp_first = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_CLEAR;
         clr_addr      <= '0;
         core_rvalid_q <= 1'b0;
         disp_rvalid_q <= 1'b0;
      end else begin
         state         <= state_nxt;
         clr_addr      <= clr_addr_nxt;
         core_rvalid_q <= core_gnt && !core_we;
         disp_rvalid_q <= disp_gnt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      clear_busy   = 1'b0;
      core_gnt     = 1'b0;
      disp_gnt     = 1'b0;
      mem_addr     = '0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      if (reset) begin
         case (state)
            ST_CLEAR: begin
               clear_busy = 1'b1;
               mem_we     = 1'b1;
               mem_addr   = clr_addr;
               if (clr_addr == CLR_LAST) begin
                  clr_addr_nxt = '0;
                  state_nxt    = ST_SERVE;
               end else begin
                  clr_addr_nxt = clr_addr + ADDR_W'(1);
               end
            end
            ST_SERVE: begin
               if (clear_req) begin
                  clr_addr_nxt = '0;
                  state_nxt    = ST_CLEAR;
               end else if (disp_first) begin
                  disp_gnt = 1'b1;
                  mem_addr = disp_addr;
               end else if (core_req) begin
                  core_gnt  = 1'b1;
                  mem_addr  = core_addr;
                  mem_we    = core_we;
                  mem_wdata = core_wdata;
               end else if (disp_req) begin
                  disp_gnt = 1'b1;
                  mem_addr = disp_addr;
               end
            end
            default: state_nxt = ST_CLEAR;
         endcase
      end
   end

   assign core_rvalid = core_rvalid_q & reset;
   assign disp_rvalid = disp_rvalid_q & reset;
   assign core_rdata  = reset ? mem_rdata : '0;
   assign disp_rdata  = reset ? mem_rdata : '0;

endmodule

// File: tb/tb_bf_data_mem_sched.sv
// Directed bench for bf_data_mem_sched with a behavioural sync-read RAM model.
module tb_bf_data_mem_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear_req;
   logic       clear_busy;
   logic       core_req, core_we;
   logic [7:0] core_addr, core_wdata;
   logic       core_gnt, core_rvalid;
   logic [7:0] core_rdata;
   logic       disp_req;
   logic [7:0] disp_addr;
   logic       disp_gnt, disp_rvalid;
   logic [7:0] disp_rdata;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic [7:0] ram [256];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   bf_data_mem_sched dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full clear: called just after the edge that first sees the controller in CLEAR.
   task automatic check_clear(input string tag);
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         check({tag, " busy"}, 32'(clear_busy), 32'd1);
         check({tag, " we"}, 32'(mem_we), 32'd1);
         check({tag, " addr"}, 32'(mem_addr), 32'(i));
         check({tag, " wdata"}, 32'(mem_wdata), 32'd0);
         step();
      end
      @(negedge clk);
      check({tag, " done"}, 32'(clear_busy), 32'd0);
      step();
   endtask

   task automatic core_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] exp_rdata);
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
      @(negedge clk);
      check("core gnt", 32'(core_gnt), 32'd1);
      check("core mem_we", 32'(mem_we), 32'(we));
      check("core mem_addr", 32'(mem_addr), 32'(addr));
      if (we) check("core mem_wdata", 32'(mem_wdata), 32'(wdata));
      step();
      core_req = 1'b0; core_we = 1'b0;
      @(negedge clk);
      check("core rvalid", 32'(core_rvalid), 32'(!we));
      if (!we) check("core rdata", 32'(core_rdata), 32'(exp_rdata));
      step();
   endtask

   task automatic disp_read(input logic [7:0] addr, input logic [7:0] exp_rdata);
      disp_req = 1'b1; disp_addr = addr;
      @(negedge clk);
      check("disp gnt", 32'(disp_gnt), 32'd1);
      check("disp mem_we", 32'(mem_we), 32'd0);
      check("disp mem_addr", 32'(mem_addr), 32'(addr));
      step();
      disp_req = 1'b0;
      @(negedge clk);
      check("disp rvalid", 32'(disp_rvalid), 32'd1);
      check("disp rdata", 32'(disp_rdata), 32'(exp_rdata));
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < 256; i++) ram[i] = 8'hFF;
      reset = 1'b0; clear_req = 1'b0;
      core_req = 1'b1; core_we = 1'b1; core_addr = 8'd1; core_wdata = 8'h11;
      disp_req = 1'b0; disp_addr = 8'd0;
      repeat (3) step();
      @(negedge clk);
      check("rst busy", 32'(clear_busy), 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst core_gnt", 32'(core_gnt), 32'd0);
      check("rst core_rvalid", 32'(core_rvalid), 32'd0);
      check("rst disp_rvalid", 32'(disp_rvalid), 32'd0);
      step();
      core_req = 1'b0; core_we = 1'b0;
      reset = 1'b1;
      check_clear("clr1");

      // write then read back, plus back-to-back write/read of another cell
      core_access(1'b1, 8'd5, 8'h2A, 8'h00);
      core_access(1'b0, 8'd5, 8'h00, 8'h2A);
      core_access(1'b0, 8'd9, 8'h00, 8'h00);
      core_req = 1'b1; core_we = 1'b1; core_addr = 8'd7; core_wdata = 8'h55;
      step();
      core_we = 1'b0;
      @(negedge clk);
      check("b2b rd gnt", 32'(core_gnt), 32'd1);
      check("b2b rd we", 32'(mem_we), 32'd0);
      step();
      core_req = 1'b0;
      @(negedge clk);
      check("b2b rvalid", 32'(core_rvalid), 32'd1);
      check("b2b rdata", 32'(core_rdata), 32'h55);
      step();

      core_access(1'b1, 8'd3, 8'h07, 8'h00);
      disp_read(8'd3, 8'h07);
      disp_read(8'd200, 8'h00);

      // both ports requesting continuously
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'd5; disp_req = 1'b1; disp_addr = 8'd3;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
`ifdef BF_STARVE_GUARD_EN
         check("contend disp_gnt", 32'(disp_gnt), 32'(i == 8));
         check("contend core_gnt", 32'(core_gnt), 32'(i != 8));
`else
         check("contend disp_gnt", 32'(disp_gnt), 32'd0);
         check("contend core_gnt", 32'(core_gnt), 32'd1);
`endif
         step();
      end
      disp_req = 1'b0;

      // clear request wins over a held core request
      core_we = 1'b1; core_addr = 8'd5; core_wdata = 8'h99; clear_req = 1'b1;
      @(negedge clk);
      check("clrreq gnt", 32'(core_gnt), 32'd0);
      check("clrreq we", 32'(mem_we), 32'd0);
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         check("clr2 busy", 32'(clear_busy), 32'd1);
         check("clr2 core_gnt", 32'(core_gnt), 32'd0);
         check("clr2 addr", 32'(mem_addr), 32'(i));
         step();
      end
      @(negedge clk);
      check("clr2 first serve gnt", 32'(core_gnt), 32'd1);
      check("clr2 first serve busy", 32'(clear_busy), 32'd0);
      step();
      core_req = 1'b0; core_we = 1'b0;
      core_access(1'b0, 8'd5, 8'h00, 8'h99);
      core_access(1'b0, 8'd3, 8'h00, 8'h00);

      // reset in the middle of a clear
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (mem_addr == 8'd100) seen = 1'b1;
         else step();
      end
      check("abort reached addr 100", 32'(seen), 32'd1);
      reset = 1'b0;
      #1;
      check("abort busy", 32'(clear_busy), 32'd0);
      check("abort we", 32'(mem_we), 32'd0);
      check("abort addr", 32'(mem_addr), 32'd0);
      step();
      step();
      reset = 1'b1;
      check_clear("clr3");
      disp_read(8'd7, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
